// File: rtl/ddr_axi_initiator.sv
// Single-burst AXI traffic initiator for one DDR controller user port.
// Writes a seeded incrementing pattern and checks read-back data, ID and last-beat alignment.
module ddr_axi_initiator #(
    parameter int   CTRL_ADDR_WIDTH = 28,
    parameter int   DATA_WIDTH      = 256,
    parameter logic AP_DEFAULT      = 1'b0
) (
    input  logic                         core_clk,
    input  logic                         core_rst,
    input  logic                         ddr_init_done,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [CTRL_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [3:0]                   cmd_len,
    input  logic [3:0]                   cmd_id,
    input  logic [31:0]                  cmd_seed,
    input  logic                         err_clr,
    output logic [CTRL_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [3:0]                   axi_awlen,
    output logic [3:0]                   axi_awuser_id,
    output logic                         axi_awuser_ap,
    output logic                         axi_awvalid,
    input  logic                         axi_awready,
    output logic [DATA_WIDTH-1:0]        axi_wdata,
    output logic [DATA_WIDTH/8-1:0]      axi_wstrb,
    input  logic                         axi_wready,
    input  logic                         axi_wusero_last,
    input  logic [3:0]                   axi_wusero_id,
    output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
    output logic [3:0]                   axi_arlen,
    output logic [3:0]                   axi_aruser_id,
    output logic                         axi_aruser_ap,
    output logic                         axi_arvalid,
    input  logic                         axi_arready,
    input  logic [DATA_WIDTH-1:0]        axi_rdata,
    input  logic [3:0]                   axi_rid,
    input  logic                         axi_rlast,
    input  logic                         axi_rvalid,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  err_cnt,
    output logic                         err_flag
);

    localparam int WORDS = DATA_WIDTH / 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_AR   = 3'd3,
        S_R    = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                       state_q, state_d;
    logic [CTRL_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]                   len_q, len_d;
    logic [3:0]                   id_q, id_d;
    logic [31:0]                  seed_q, seed_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         awvalid_q, awvalid_d;
    logic                         arvalid_q, arvalid_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [15:0]                  err_cnt_q, err_cnt_d;
    logic                         err_flag_q, err_flag_d;

    logic                         last_beat_s;
    logic                         beat_err_s;
    logic                         stray_s;
    logic [1:0]                   err_add_s;
    logic [16:0]                  err_sum_s;

    // Word i of beat k is seed + k*WORDS + i, wrapping mod 2^32.
    function automatic logic [DATA_WIDTH-1:0] beat_pattern(input logic [31:0] seed,
                                                           input logic [3:0]  beat);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WORDS; i++) begin
            v[i*32 +: 32] = seed + (32'(beat) * 32'(WORDS)) + 32'(i);
        end
        return v;
    endfunction

    // Next-state, burst bookkeeping and error accounting.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        id_d        = id_q;
        seed_d      = seed_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        beat_err_s  = 1'b0;
        last_beat_s = (cnt_q == len_q);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    seed_d  = cmd_seed;
                    cnt_d   = 4'd0;
                    state_d = cmd_write ? S_AW : S_AR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                if (axi_awready) begin
                    state_d = S_W;
                end else begin
                    state_d = S_AW;
                end
            end
            S_W: begin
                if (axi_wready) begin
                    beat_err_s = (axi_wusero_last != last_beat_s) || (axi_wusero_id != id_q);
                    cnt_d      = cnt_q + 4'd1;
                    state_d    = last_beat_s ? S_DONE : S_W;
                end else begin
                    state_d = S_W;
                end
            end
            S_AR: begin
                if (axi_arready) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (axi_rvalid) begin
                    beat_err_s = (axi_rdata != beat_pattern(seed_q, cnt_q)) ||
                                 (axi_rid != id_q) || (axi_rlast != last_beat_s);
                    cnt_d      = cnt_q + 4'd1;
                    state_d    = last_beat_s ? S_DONE : S_R;
                end else begin
                    state_d = S_R;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Data register leads the beat counter so the next beat is ready right after wready.
        if (state_d == S_W) begin
            wdata_d = beat_pattern(seed_q, cnt_d);
        end else begin
            wdata_d = wdata_q;
        end

        stray_s   = axi_rvalid && (state_q != S_R);
        err_add_s = {1'b0, beat_err_s} + {1'b0, stray_s};
        err_sum_s = {1'b0, err_cnt_q} + {15'd0, err_add_s};

        if (err_clr) begin
            err_cnt_d  = 16'd0;
            err_flag_d = 1'b0;
        end else if (err_add_s != 2'd0) begin
            err_cnt_d  = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
            err_flag_d = 1'b1;
        end else begin
            err_cnt_d  = err_cnt_q;
            err_flag_d = err_flag_q;
        end

        cmd_ready_d = (state_d == S_IDLE) && ddr_init_done;
        awvalid_d   = (state_d == S_AW);
        arvalid_d   = (state_d == S_AR);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= 4'd0;
            id_q        <= 4'd0;
            seed_q      <= 32'd0;
            cnt_q       <= 4'd0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cnt_q   <= 16'd0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            id_q        <= id_d;
            seed_q      <= seed_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            arvalid_q   <= arvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign axi_awaddr    = addr_q;
    assign axi_awlen     = len_q;
    assign axi_awuser_id = id_q;
    assign axi_awuser_ap = AP_DEFAULT;
    assign axi_awvalid   = awvalid_q;
    assign axi_wdata     = wdata_q;
    assign axi_wstrb     = {(DATA_WIDTH/8){1'b1}};
    assign axi_araddr    = addr_q;
    assign axi_arlen     = len_q;
    assign axi_aruser_id = id_q;
    assign axi_aruser_ap = AP_DEFAULT;
    assign axi_arvalid   = arvalid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_cnt       = err_cnt_q;
    assign err_flag      = err_flag_q;

endmodule

// File: tb/tb_ddr_axi_initiator.sv
// Self-checking bench for ddr_axi_initiator: a table of directed bursts, hand-written
// corner sequences and random bursts, checked against a word-stream pattern model.
module tb_ddr_axi_initiator;

    localparam int AW = 28;
    localparam int DW = 256;
    localparam int NW = DW / 32;

    logic            core_clk = 1'b0;
    logic            core_rst;
    logic            ddr_init_done;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [3:0]      cmd_len;
    logic [3:0]      cmd_id;
    logic [31:0]     cmd_seed;
    logic            err_clr;
    logic [AW-1:0]   axi_awaddr;
    logic [3:0]      axi_awlen;
    logic [3:0]      axi_awuser_id;
    logic            axi_awuser_ap;
    logic            axi_awvalid;
    logic            axi_awready;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wready;
    logic            axi_wusero_last;
    logic [3:0]      axi_wusero_id;
    logic [AW-1:0]   axi_araddr;
    logic [3:0]      axi_arlen;
    logic [3:0]      axi_aruser_id;
    logic            axi_aruser_ap;
    logic            axi_arvalid;
    logic            axi_arready;
    logic [DW-1:0]   axi_rdata;
    logic [3:0]      axi_rid;
    logic            axi_rlast;
    logic            axi_rvalid;
    logic            busy;
    logic            done;
    logic [15:0]     err_cnt;
    logic            err_flag;

    ddr_axi_initiator dut (
        .core_clk(core_clk), .core_rst(core_rst), .ddr_init_done(ddr_init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_seed(cmd_seed),
        .err_clr(err_clr),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awuser_id(axi_awuser_id),
        .axi_awuser_ap(axi_awuser_ap), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
        .axi_wusero_last(axi_wusero_last), .axi_wusero_id(axi_wusero_id),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_aruser_id(axi_aruser_id),
        .axi_aruser_ap(axi_aruser_ap), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .busy(busy), .done(done), .err_cnt(err_cnt), .err_flag(err_flag)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        bit          wr;
        logic [27:0] addr;
        logic [3:0]  len;
        logic [3:0]  id;
        logic [31:0] seed;
        int          aw_dly;
        int          gap_pct;
        int          f_data;
        int          f_id;
        int          f_last;
        int          exp_err;
    } vec_t;

    vec_t tbl[8];
    int   checks   = 0;
    int   errors   = 0;
    int   exp_err  = 0;
    bit   exp_flag = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready", DW'(cmd_ready), DW'(0));
        chk("rst_awvalid", DW'(axi_awvalid), DW'(0));
        chk("rst_arvalid", DW'(axi_arvalid), DW'(0));
        chk("rst_awaddr", DW'(axi_awaddr), DW'(0));
        chk("rst_awlen_id", DW'({axi_awlen, axi_awuser_id}), DW'(0));
        chk("rst_wdata", axi_wdata, DW'(0));
        chk("rst_wstrb", DW'(axi_wstrb), DW'({(DW/8){1'b1}}));
        chk("rst_busy_done", DW'({busy, done}), DW'(0));
        chk("rst_err", DW'({err_flag, err_cnt}), DW'(0));
    endtask

    // Drive one burst from the command port through the controller-side handshakes.
    task automatic run_burst(input vec_t v);
        logic [31:0]   word;
        logic [DW-1:0] beat;
        logic [DW-1:0] flip;
        int            n;
        word    = v.seed;
        flip    = '0;
        flip[7] = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_id    = v.id;
        cmd_seed  = v.seed;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge core_clk);
            n++;
        end
        chk("cmd_ready_wait", DW'(n < 200), DW'(1));
        if (n >= 200) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge core_clk);
        cmd_valid = 1'b0;
        if (v.wr) begin
            chk("awvalid", DW'({axi_awvalid, axi_arvalid}), DW'(2'b10));
            chk("aw_fields", DW'({axi_awaddr, axi_awlen, axi_awuser_id, axi_awuser_ap}),
                DW'({v.addr, v.len, v.id, 1'b0}));
            repeat (v.aw_dly) @(negedge core_clk);
            chk("awvalid_hold", DW'(axi_awvalid), DW'(1));
            axi_awready = 1'b1;
            @(negedge core_clk);
            axi_awready = 1'b0;
            chk("awvalid_drop", DW'(axi_awvalid), DW'(0));
        end else begin
            chk("arvalid", DW'({axi_arvalid, axi_awvalid}), DW'(2'b10));
            chk("ar_fields", DW'({axi_araddr, axi_arlen, axi_aruser_id, axi_aruser_ap}),
                DW'({v.addr, v.len, v.id, 1'b0}));
            repeat (v.aw_dly) @(negedge core_clk);
            chk("arvalid_hold", DW'(axi_arvalid), DW'(1));
            axi_arready = 1'b1;
            @(negedge core_clk);
            axi_arready = 1'b0;
            chk("arvalid_drop", DW'(axi_arvalid), DW'(0));
        end
        for (int k = 0; k <= int'(v.len); k++) begin
            for (int i = 0; i < NW; i++) begin
                beat[i*32 +: 32] = word;
                word = word + 32'd1;
            end
            n = 0;
            while (n < 6 && int'($urandom_range(99)) < v.gap_pct) begin
                @(negedge core_clk);
                n++;
            end
            if (v.wr) begin
                chk("wdata", axi_wdata, beat);
                axi_wready      = 1'b1;
                axi_wusero_last = (k == int'(v.len)) ^ (k == v.f_last);
                axi_wusero_id   = (k == v.f_id) ? v.id + 4'd1 : v.id;
            end else begin
                axi_rvalid = 1'b1;
                axi_rdata  = (k == v.f_data) ? (beat ^ flip) : beat;
                axi_rid    = (k == v.f_id) ? v.id + 4'd1 : v.id;
                axi_rlast  = (k == int'(v.len)) ^ (k == v.f_last);
            end
            @(negedge core_clk);
            axi_wready      = 1'b0;
            axi_wusero_last = 1'b0;
            axi_rvalid      = 1'b0;
            axi_rlast       = 1'b0;
            if (k < int'(v.len)) chk("done_early", DW'(done), DW'(0));
        end
        exp_err = (exp_err + v.exp_err > 65535) ? 65535 : exp_err + v.exp_err;
        if (v.exp_err != 0) exp_flag = 1'b1;
        chk("done_pulse", DW'({done, busy}), DW'(2'b11));
        chk("err_cnt", DW'(err_cnt), DW'(exp_err));
        chk("err_flag", DW'(err_flag), DW'(exp_flag));
        @(negedge core_clk);
        chk("done_drop", DW'({done, busy}), DW'(0));
    endtask

    initial begin
        vec_t v;
        int   n;
        core_rst = 1'b1; ddr_init_done = 1'b1; err_clr = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 4'd0; cmd_id = 4'd0;
        cmd_seed = 32'd0; axi_awready = 1'b0; axi_wready = 1'b0; axi_wusero_last = 1'b0;
        axi_wusero_id = 4'd0; axi_arready = 1'b0; axi_rdata = '0; axi_rid = 4'd0;
        axi_rlast = 1'b0; axi_rvalid = 1'b0;

        //                wr    addr         len   id    seed           dly gap  fdat fid flast exp
        tbl[0] = '{1'b1, 28'h100,     4'd3, 4'd5, 32'h0000_1000, 4, 50, -1, -1, -1, 0};
        tbl[1] = '{1'b0, 28'h100,     4'd3, 4'd5, 32'h0000_1000, 2, 30, -1, -1, -1, 0};
        tbl[2] = '{1'b0, 28'h100,     4'd3, 4'd5, 32'h0000_1000, 0, 30,  2,  0, -1, 2};
        tbl[3] = '{1'b1, 28'h0ABCDEF, 4'd0, 4'd1, 32'hFFFF_FFFC, 1,  0, -1, -1, -1, 0};
        tbl[4] = '{1'b0, 28'h0ABCDEF, 4'd0, 4'd1, 32'hFFFF_FFFC, 0,  0, -1, -1, -1, 0};
        tbl[5] = '{1'b0, 28'h2000,    4'd2, 4'd9, 32'h1234_5678, 1, 20, -1, -1,  1, 1};
        tbl[6] = '{1'b1, 28'h3000,    4'd2, 4'd7, 32'h8000_0000, 0,  0, -1,  0,  2, 2};
        tbl[7] = '{1'b0, 28'h4000,    4'd1, 4'd2, 32'hDEAD_BEEF, 3, 40,  1,  1,  1, 1};

        repeat (3) @(negedge core_clk);
        chk_reset_vals();

        core_rst = 1'b0; ddr_init_done = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge core_clk);
            if (cmd_ready || axi_awvalid || busy) n++;
        end
        chk("init_done_low_refuse", DW'(n), DW'(0));
        cmd_valid = 1'b0; ddr_init_done = 1'b1;
        @(negedge core_clk);

        for (int t = 0; t < 8; t++) begin
            if (t == 3) begin
                err_clr = 1'b1;
                @(negedge core_clk);
                err_clr = 1'b0;
                chk("err_clr", DW'({err_flag, err_cnt}), DW'(0));
                exp_err = 0; exp_flag = 1'b0;
            end
            run_burst(tbl[t]);
        end

        // Stray rvalid outside R, then err_clr winning over a simultaneous stray beat.
        err_clr = 1'b1;
        @(negedge core_clk);
        err_clr = 1'b0;
        axi_rvalid = 1'b1;
        @(negedge core_clk);
        axi_rvalid = 1'b0;
        chk("stray_rvalid", DW'({err_flag, err_cnt}), DW'({1'b1, 16'd1}));
        err_clr = 1'b1; axi_rvalid = 1'b1;
        @(negedge core_clk);
        err_clr = 1'b0; axi_rvalid = 1'b0;
        chk("clr_priority", DW'({err_flag, err_cnt}), DW'(0));
        exp_err = 0; exp_flag = 1'b0;

        // Reset in the middle of a write burst, after two beats (one with a bad ID).
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 28'h200; cmd_len = 4'd7;
        cmd_id = 4'd3; cmd_seed = 32'h0000_0ABC;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge core_clk);
            n++;
        end
        @(negedge core_clk);
        cmd_valid = 1'b0; axi_awready = 1'b1;
        @(negedge core_clk);
        axi_awready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            axi_wready = 1'b1; axi_wusero_last = 1'b0;
            axi_wusero_id = (b == 0) ? 4'd4 : 4'd3;
            @(negedge core_clk);
            axi_wready = 1'b0;
        end
        chk("midburst_wdata", axi_wdata[31:0], DW'(32'h0000_0ABC + 32'd16));
        chk("midburst_err", DW'({busy, err_cnt}), DW'({1'b1, 16'd1}));
        core_rst = 1'b1;
        @(negedge core_clk);
        core_rst = 1'b0;
        chk_reset_vals();
        exp_err = 0; exp_flag = 1'b0;
        run_burst('{1'b1, 28'h300, 4'd5, 4'd6, 32'h5555_0000, 1, 30, -1, -1, -1, 0});

        // Random bursts with occasional injected faults.
        for (int r = 0; r < 25; r++) begin
            v.wr      = 1'($urandom_range(1));
            v.addr    = 28'($urandom);
            v.len     = 4'($urandom_range(15));
            v.id      = 4'($urandom_range(15));
            v.seed    = $urandom;
            if (r == 0) v.seed = 32'hFFFF_FFF0;
            v.aw_dly  = int'($urandom_range(5));
            v.gap_pct = int'($urandom_range(60));
            v.f_data  = (!v.wr && $urandom_range(3) == 0) ? int'($urandom_range(int'(v.len))) : -1;
            v.f_id    = ($urandom_range(3) == 0) ? int'($urandom_range(int'(v.len))) : -1;
            v.f_last  = ($urandom_range(3) == 0) ? int'($urandom_range(int'(v.len))) : -1;
            v.exp_err = 0;
            for (int k = 0; k <= int'(v.len); k++) begin
                if (k == v.f_data || k == v.f_id || k == v.f_last) v.exp_err++;
            end
            run_burst(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
